// File: rtl/fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arbiter
// Description : 4-entry shared FIFO with independent round-robin arbitration
//               on the push and pop sides for four requesting cores.
//               At most one push and one pop are performed per clock edge.
//               Grants are registered one-hot pulses lasting one cycle.
// Ports       :
//   CLK             in   clock, all state updates on the rising edge
//   FIFOARB_RST     in   synchronous active-high reset
//   FIFOARB_Flush   in   synchronous clear of FIFO contents (RR pointers kept)
//   FIFOARB_WReq    in   [3:0] per-core push request
//   FIFOARB_WData   in   [4*DATA_W-1:0] per-core push data, core i at i*DATA_W
//   FIFOARB_RReq    in   [3:0] per-core pop request
//   FIFOARB_WGnt    out  [3:0] one-hot push grant pulse
//   FIFOARB_RGnt    out  [3:0] one-hot pop grant pulse
//   FIFOARB_RData   out  [DATA_W-1:0] popped entry, valid while RGnt is high
//   FIFOARB_Count   out  [2:0] occupancy 0..4
//   FIFOARB_Full    out  Count == 4
//   FIFOARB_Empty   out  Count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                CLK,
    input  logic                FIFOARB_RST,
    input  logic                FIFOARB_Flush,
    input  logic [3:0]          FIFOARB_WReq,
    input  logic [4*DATA_W-1:0] FIFOARB_WData,
    input  logic [3:0]          FIFOARB_RReq,
    output logic [3:0]          FIFOARB_WGnt,
    output logic [3:0]          FIFOARB_RGnt,
    output logic [DATA_W-1:0]   FIFOARB_RData,
    output logic [2:0]          FIFOARB_Count,
    output logic                FIFOARB_Full,
    output logic                FIFOARB_Empty
);

    localparam int         N_REQ   = 4;
    localparam int         DEPTH   = 4;
    localparam logic [2:0] C_FULL  = 3'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q,  count_d;
    logic [1:0]        wr_rr_q,  wr_rr_d;
    logic [1:0]        rd_rr_q,  rd_rr_d;
    logic [3:0]        wgnt_q,   wgnt_d;
    logic [3:0]        rgnt_q,   rgnt_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;

    // ------------------------------------------------------------------
    // Per-core data slices
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_wdata_core [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_wdata_core[gi] = FIFOARB_WData[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin pick: returns {found, index}. The loop runs from the
    // farthest offset down to the pointer itself so the closest eligible
    // requester (in pointer, pointer+1, ... order) is the one left standing.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // A core still holding last cycle's grant is masked out this cycle.
    logic [3:0] w_wr_elig;
    logic [3:0] w_rd_elig;
    logic [2:0] w_wr_pick;
    logic [2:0] w_rd_pick;
    logic [1:0] w_wr_idx;
    logic [1:0] w_rd_idx;
    logic       w_push;
    logic       w_pop;

    assign w_wr_elig = FIFOARB_WReq & ~wgnt_q;
    assign w_rd_elig = FIFOARB_RReq & ~rgnt_q;
    assign w_wr_pick = rr_pick(w_wr_elig, wr_rr_q);
    assign w_rd_pick = rr_pick(w_rd_elig, rd_rr_q);
    assign w_wr_idx  = w_wr_pick[1:0];
    assign w_rd_idx  = w_rd_pick[1:0];

    // Full/empty use the pre-edge count, so a same-cycle pop does not make
    // room for a push and a same-cycle push does not feed a pop.
    assign w_push = w_wr_pick[2] && (count_q != C_FULL) && !FIFOARB_Flush;
    assign w_pop  = w_rd_pick[2] && (count_q != 3'd0)   && !FIFOARB_Flush;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_rr_d  = wr_rr_q;
        rd_rr_d  = rd_rr_q;
        wgnt_d   = 4'b0000;
        rgnt_d   = 4'b0000;
        rdata_d  = rdata_q;

        if (w_push) begin
            wgnt_d[w_wr_idx] = 1'b1;
            wr_rr_d          = w_wr_idx + 2'd1;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end

        if (w_pop) begin
            rgnt_d[w_rd_idx] = 1'b1;
            rd_rr_d          = w_rd_idx + 2'd1;
            rd_ptr_d         = rd_ptr_q + 2'd1;
            rdata_d          = mem_q[rd_ptr_q];
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        // Push/pop are already suppressed during flush; only the FIFO
        // bookkeeping is cleared here.
        if (FIFOARB_Flush) begin
            count_d  = 3'd0;
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (FIFOARB_RST) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            wr_rr_q  <= 2'd0;
            rd_rr_q  <= 2'd0;
            wgnt_q   <= 4'b0000;
            rgnt_q   <= 4'b0000;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_rr_q  <= wr_rr_d;
            rd_rr_q  <= rd_rr_d;
            wgnt_q   <= wgnt_d;
            rgnt_q   <= rgnt_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is not reset; only occupancy tracking defines what is valid.
    always_ff @(posedge CLK) begin
        if (!FIFOARB_RST && w_push) begin
            mem_q[wr_ptr_q] <= w_wdata_core[w_wr_idx];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign FIFOARB_WGnt  = wgnt_q;
    assign FIFOARB_RGnt  = rgnt_q;
    assign FIFOARB_RData = rdata_q;
    assign FIFOARB_Count = count_q;
    assign FIFOARB_Full  = (count_q == C_FULL);
    assign FIFOARB_Empty = (count_q == 3'd0);

endmodule
`default_nettype wire

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of each FIFO entry.
REQ-002 Parameter N_REQ, fixed at 4, number of requesting cores; DEPTH fixed at 4 entries.
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 FIFOARB_RST  input  1  reset, synchronous, active-high.
REQ-005 FIFOARB_Flush  input  1  synchronous clear of FIFO contents; arbitration pointers are kept.
REQ-006 FIFOARB_WReq  input  4  per-core push request, one bit per core.
REQ-007 FIFOARB_WData  input  4*DATA_W  per-core push data; core i occupies bits [i*DATA_W +: DATA_W].
REQ-008 FIFOARB_RReq  input  4  per-core pop request.
REQ-009 FIFOARB_WGnt  output reg  4  one-hot push grant, single-cycle pulse.
REQ-010 FIFOARB_RGnt  output reg  4  one-hot pop grant, single-cycle pulse.
REQ-011 FIFOARB_RData  output reg  DATA_W  popped entry, valid in the cycle RGnt is high.
REQ-012 FIFOARB_Count  output reg  3  occupancy, 0..4.
REQ-013 FIFOARB_Full / FIFOARB_Empty  output  1 each  Count==4 / Count==0, decoded from Count.

Function
REQ-014 Push and pop sides SHALL arbitrate independently; at most one push and one pop per cycle.
REQ-015 Eligible push requesters SHALL be WReq & ~WGnt; eligible pop requesters SHALL be RReq & ~RGnt.
- A core holding a grant is masked for that cycle.
- A core SHALL drop its request in the cycle it sees its grant.
REQ-016 Round-robin: each side keeps a 2-bit pointer.
- Search order SHALL be pointer, pointer+1, ... (mod 4).
- After a grant to core k, the pointer SHALL become k+1 (mod 4).
- The pointer SHALL be unchanged when no grant is issued.
REQ-017 Push SHALL occur on an edge only if an eligible push requester exists and Count<4.
- The winner's data is written at the write pointer.
- WGnt[winner]=1 SHALL be registered for the next cycle.
REQ-018 Pop SHALL occur on an edge only if an eligible pop requester exists and Count>0.
- The head entry is registered into RData.
- RGnt[winner]=1 SHALL be registered for the next cycle.
REQ-019 Grant latency SHALL be 1 cycle: request sampled at edge N, grant high during cycle N..N+1, grant low the following cycle unless re-won.
REQ-020 Full is evaluated on the pre-edge Count: push SHALL be blocked at Count==4 even if a pop occurs in the same cycle.
REQ-021 Empty is evaluated on the pre-edge Count: pop SHALL be blocked at Count==0 even if a push occurs in the same cycle.
REQ-022 Count SHALL update +1 on push only, -1 on pop only, and hold on both or neither; it never wraps.
REQ-023 Read/write pointers SHALL be 2-bit and wrap 3->0.
REQ-024 FIFO ordering SHALL be strictly first-in first-out across all cores.
REQ-025 RData SHALL hold its last value when no pop occurs.
REQ-026 Flush=1 SHALL set Count, read pointer and write pointer to 0 and clear WGnt/RGnt on that edge.
- No push or pop occurs in a flush cycle.
- Round-robin pointers and RData hold.

Reset
REQ-027 On a rising edge with FIFOARB_RST=1, the following SHALL all be 0:
- Count, read/write pointers, both round-robin pointers, WGnt, RGnt, RData.
REQ-028 Reset SHALL take priority over Flush and all requests, including mid-operation; storage contents need not be cleared.
REQ-029 After reset: Empty=1, Full=0, and core 0 has first priority on both sides.

Verification
REQ-030 Reset, then WReq=4'b1111 with WData core0..3 = 0x10,0x11,0x12,0x13, held per REQ-015 -> WGnt sequence 0001,0010,0100,1000; Count 1..4; Full=1.
REQ-031 Full FIFO, WReq[2]=1 and RReq[1]=1 together -> RGnt=0010 with RData=0x10; no WGnt; Count 4->3; next cycle WGnt=0100, Count 3->4.
REQ-032 Empty FIFO, WReq[0]=1 and RReq[3]=1 together -> WGnt=0001, no RGnt, Count=1; next cycle RGnt=1000 with RData equal to core 0's data.
REQ-033 Count=2, simultaneous eligible push and pop -> both grants pulse, Count stays 2, data order preserved.
REQ-034 Count=3, then Flush=1 -> Count=0, Empty=1, no grants that cycle, RR pointers unchanged; a subsequent pop request gets no grant until a push occurs.
REQ-035 Continuous requests from cores 1 and 3 -> grants alternate 0010,1000 for 8 cycles; wrap of read/write pointers past 3 gives correct FIFO order; RST asserted mid-stream -> all outputs 0 on the next cycle.
